delay_out_fifo: RTL and testbench

- Buffers the output of the `delay` block; sits directly downstream of it.
- Accepts the `dout`/`dvalid` stream, which has no backpressure, into a first-word-fall-through FIFO.
- Presents the buffered words to the next stage with a valid/ready handshake.
- Detects words lost when the FIFO is full and counts them, so software or a bench can spot under-sized buffering.

---
 rtl/delay_pkg.sv | 27 ++
 rtl/delay_out_fifo_sat_counter.sv | 43 ++++
 rtl/delay_out_fifo.sv | 114 +++++++++++
 tb/tb_delay_out_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for the delay block and its output buffering stage.
package delay_pkg;

  // Default sizing for the delay output FIFO
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_DEPTH          = 16;
  localparam int DEFAULT_AFULL_LEVEL    = 12;
  localparam int DEFAULT_DROP_CNT_WIDTH = 16;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Pointer width for a FIFO of the given depth: address bits plus one wrap bit
  function automatic int ptrWidth(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/delay_out_fifo_sat_counter.sv
// Saturating event counter. An increment in the same cycle as a clear wins,
// leaving the counter at one so that the coincident event is not lost.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] SAT = {WIDTH{1'b1}};

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: increment (restarting from one on a clear), clear, or hold
  always_comb begin
    value_d = value_q;
    if (inc) begin
      if (clr) begin
        value_d = WIDTH'(1);
      end else if (value_q != SAT) begin
        value_d = value_q + WIDTH'(1);
      end
    end else if (clr) begin
      value_d = '0;
    end
  end

  // Counter register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/delay_out_fifo.sv
// First-word-fall-through buffer behind the delay block. The upstream stream
// has no backpressure, so words arriving while full are dropped and counted.
module delay_out_fifo
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int AFULL_LEVEL    = DEFAULT_AFULL_LEVEL,
  parameter int DROP_CNT_WIDTH = DEFAULT_DROP_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       dvalid,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [clog2(DEPTH):0]      count,
  output logic                       afull,
  output logic                       full,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [DROP_CNT_WIDTH-1:0]  drop_count
);

  localparam int PTR_W  = ptrWidth(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] AFULL_THRESH = PTR_W'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic                  overflow_q, overflow_d;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Status derived purely from the registered pointers
  always_comb begin
    empty = (wrPtr_q == rdPtr_q);
    full  = (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]) &&
            (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]);
    count = wrPtr_q - rdPtr_q;
    afull = (count >= AFULL_THRESH);
    dout_valid = ~empty;
  end

  // Head word is shown only while valid so stale memory never leaks out
  always_comb begin
    dout = '0;
    if (dout_valid) begin
      dout = mem_q[rdPtr_q[ADDR_W-1:0]];
    end
  end

  // Transfer decisions; a pop frees a slot so a full FIFO can still accept
  always_comb begin
    pop  = dout_valid & dout_ready;
    push = dvalid & (~full | pop);
    drop = dvalid & full & ~pop;
  end

  // Pointer and sticky-overflow next state
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Pointer and overflow registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[ADDR_W-1:0]] <= din;
    end
  end

  assign overflow = overflow_q;

  sat_counter #(
    .WIDTH(DROP_CNT_WIDTH)
  ) u_dropCounter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (drop),
    .clr  (overflow_clr),
    .value(drop_count)
  );

endmodule

// File: tb/tb_delay_out_fifo.sv
// Self-checking bench for delay_out_fifo using a queue-based reference model.
module tb_delay_out_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          dvalid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [4:0]    count;
  logic          afull;
  logic          full;
  logic          overflow;
  logic          overflow_clr;
  logic [CW-1:0] drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] modelQ[$];
  logic          modelOvf;
  int            modelDrops;

  delay_out_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AFULL_LEVEL(AFL),
    .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .dvalid(dvalid),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .count(count),
    .afull(afull),
    .full(full),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .drop_count(drop_count)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkAll(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(modelQ.size()));
    checkOutput({tag, ".dout_valid"}, 32'(dout_valid), 32'(modelQ.size() > 0));
    checkOutput({tag, ".dout"}, 32'(dout), (modelQ.size() > 0) ? 32'(modelQ[0]) : 32'd0);
    checkOutput({tag, ".full"}, 32'(full), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".afull"}, 32'(afull), 32'(modelQ.size() >= AFL));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(modelOvf));
    checkOutput({tag, ".drop_count"}, 32'(drop_count), 32'(modelDrops));
  endtask

  // One clock cycle: drive inputs just after a falling edge, update the model at
  // the rising edge, then compare at the following falling edge
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                               input logic c, input string tag);
    bit mPop, mPush, mDrop;
    dvalid       = v;
    din          = v ? d : DW'($urandom);
    dout_ready   = r;
    overflow_clr = c;
    mPop  = (modelQ.size() > 0) && r;
    mPush = v && ((modelQ.size() < DEPTH) || mPop);
    mDrop = v && (modelQ.size() == DEPTH) && !mPop;
    @(posedge clk);
    if (mPop) void'(modelQ.pop_front());
    if (mPush) modelQ.push_back(d);
    if (mDrop) begin
      modelOvf = 1'b1;
      if (c) modelDrops = 1;
      else if (modelDrops < (1 << CW) - 1) modelDrops++;
    end else if (c) begin
      modelOvf   = 1'b0;
      modelDrops = 0;
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf   = 1'b0;
    modelDrops = 0;
  endtask

  initial begin
    rst_n        = 1'b0;
    din          = '0;
    dvalid       = 1'b0;
    dout_ready   = 1'b0;
    overflow_clr = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    // 1: two words buffered, then drained in order
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b0, "t1push");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, "t1push");
    checkOutput("t1.count2", 32'(count), 32'd2);
    checkOutput("t1.headAB", 32'(dout), 32'hAB);
    checkOutput("t1.valid", 32'(dout_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t1pop");
    checkOutput("t1.head11", 32'(dout), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t1pop");
    checkOutput("t1.emptyValid", 32'(dout_valid), 32'd0);
    checkOutput("t1.emptyDout", 32'(dout), 32'd0);

    // 2: overfill with 20 words, last 4 dropped
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, "t2fill");
      if (i == 10) checkOutput("t2.afullBelow", 32'(afull), 32'd0);
      if (i == 11) checkOutput("t2.afullAt12", 32'(afull), 32'd1);
      if (i == 14) checkOutput("t2.notFull15", 32'(full), 32'd0);
      if (i == 15) checkOutput("t2.full16", 32'(full), 32'd1);
    end
    checkOutput("t2.overflow", 32'(overflow), 32'd1);
    checkOutput("t2.drops4", 32'(drop_count), 32'd4);

    // 3: push and pop together while full; no drops, order preserved
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3.head", 32'(dout), 32'(i));
      applyStimulus(1'b1, DW'(100 + i), 1'b1, 1'b0, "t3flow");
      checkOutput("t3.count16", 32'(count), 32'd16);
      checkOutput("t3.drops", 32'(drop_count), 32'd4);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 11) checkOutput("t3.drainOrder", 32'(dout), 32'(i + 5));
      else checkOutput("t3.drainOrder", 32'(dout), 32'(100 + i - 11));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t3drain");
    end

    // 4: 40 words with random consumer, guarded so the buffer never overflows
    for (int i = 0; i < 40; i++) begin
      logic r;
      r = ($urandom_range(0, 1) == 1) || (modelQ.size() >= DEPTH - 1);
      applyStimulus(1'b1, DW'($urandom), r, 1'b0, "t4stream");
    end
    while (modelQ.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t4drain");
    checkOutput("t4.noNewDrops", 32'(drop_count), 32'd4);

    // 5: clear coinciding with a drop, then clear alone
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0, "t5fill");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, "t5clrDrop");
    checkOutput("t5.ovfWins", 32'(overflow), 32'd1);
    checkOutput("t5.drops1", 32'(drop_count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "t5clr");
    checkOutput("t5.ovfClr", 32'(overflow), 32'd0);
    checkOutput("t5.dropsClr", 32'(drop_count), 32'd0);
    while (modelQ.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t5drain");

    // Random mix of all inputs
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 15) == 0), "rand");
    end

    // 6: asynchronous reset in the middle of a cycle
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, 1'b0, "t6push");
    #2;
    dvalid = 1'b0;
    rst_n  = 1'b0;
    modelReset();
    #1;
    checkOutput("t6.countAsync", 32'(count), 32'd0);
    checkOutput("t6.validAsync", 32'(dout_valid), 32'd0);
    checkOutput("t6.doutAsync", 32'(dout), 32'd0);
    checkOutput("t6.ovfAsync", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, "t6after");
    checkOutput("t6.head5A", 32'(dout), 32'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t6pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
